// File: rtl/and_or_pkg.sv
// Shared widths and ALU op codes for the AND/OR datapath slice.
// DATAPATH_ADD_SUB_EN enables decoding of OP_ADD/OP_SUB in the top level.
package and_or_pkg;

  localparam int unsigned WIDTH = 32;

  typedef logic [WIDTH-1:0] word_t;

  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;

endpackage

// File: rtl/dp_reg32.sv
// Datapath register: synchronous active-high clear, load enable, clear wins.
module dp_reg32
  import and_or_pkg::*;
(
  input  logic  clk_i,
  input  logic  clear_i,
  input  logic  load_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t q_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/and_or_datapath.sv
// Single-bus datapath slice: register file, priority bus mux and AND/OR/inc ALU.
// DATAPATH_ADD_SUB_EN adds ADD/SUB decoding to the ALU.
module and_or_datapath
  import and_or_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        ZLowIn,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        MDRin,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [4:0]  op_code,
  input  logic [31:0] Mdatain,
  output logic [31:0] zlo_contents
);

  word_t bus;
  word_t alu_result;
  word_t mdr_d;
  word_t pc_q, mar_q, mdr_q, ir_q, y_q, zlow_q, r1_q, r2_q, r3_q;

  // Priority mux; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (PCout) begin
      bus = pc_q;
    end else if (Zlowout) begin
      bus = zlow_q;
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (R2out) begin
      bus = r2_q;
    end else if (R3out) begin
      bus = r3_q;
    end
  end

  always_comb begin
    alu_result = '0;
    if (IncPC) begin
      alu_result = bus + word_t'(1);
    end else begin
      case (op_code)
        OP_AND:  alu_result = y_q & bus;
        OP_OR:   alu_result = y_q | bus;
`ifdef DATAPATH_ADD_SUB_EN
        OP_ADD:  alu_result = y_q + bus;
        OP_SUB:  alu_result = y_q - bus;
`endif
        default: alu_result = '0;
      endcase
    end
  end

  assign mdr_d = Read ? Mdatain : bus;

  dp_reg32 u_pc   (.clk_i(Clock), .clear_i(Clear), .load_i(PCin),   .d_i(bus),        .q_o(pc_q));
  dp_reg32 u_mar  (.clk_i(Clock), .clear_i(Clear), .load_i(MARin),  .d_i(bus),        .q_o(mar_q));
  dp_reg32 u_mdr  (.clk_i(Clock), .clear_i(Clear), .load_i(MDRin),  .d_i(mdr_d),      .q_o(mdr_q));
  dp_reg32 u_ir   (.clk_i(Clock), .clear_i(Clear), .load_i(IRin),   .d_i(bus),        .q_o(ir_q));
  dp_reg32 u_y    (.clk_i(Clock), .clear_i(Clear), .load_i(Yin),    .d_i(bus),        .q_o(y_q));
  dp_reg32 u_zlow (.clk_i(Clock), .clear_i(Clear), .load_i(ZLowIn), .d_i(alu_result), .q_o(zlow_q));
  dp_reg32 u_r1   (.clk_i(Clock), .clear_i(Clear), .load_i(R1in),   .d_i(bus),        .q_o(r1_q));
  dp_reg32 u_r2   (.clk_i(Clock), .clear_i(Clear), .load_i(R2in),   .d_i(bus),        .q_o(r2_q));
  dp_reg32 u_r3   (.clk_i(Clock), .clear_i(Clear), .load_i(R3in),   .d_i(bus),        .q_o(r3_q));

  // MAR, IR and R1 feed logic outside this slice.
  logic unused_regs;
  assign unused_regs = ^{mar_q, ir_q, r1_q};

  assign zlo_contents = zlow_q;

endmodule

// File: tb/tb_and_or_datapath.sv
// Self-checking bench for and_or_datapath: ALU vector table, directed sequences,
// and randomized control steps against a register-array reference model.
module tb_and_or_datapath;

  logic        Clock = 1'b0;
  logic        Clear, PCout, Zlowout, MDRout, R2out, R3out;
  logic        MARin, PCin, IRin, Yin, ZLowIn, R1in, R2in, R3in, MDRin, Read, IncPC;
  logic [4:0]  op_code;
  logic [31:0] Mdatain;
  logic [31:0] zlo_contents;

  int checks = 0;
  int failures = 0;

  // Model register indices.
  localparam int PC = 0, MAR = 1, MDR = 2, IR = 3, Y = 4, Z = 5, R1 = 6, R2 = 7, R3 = 8;
  logic [31:0] m [9];

  and_or_datapath dut (
    .Clock(Clock), .Clear(Clear), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out), .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .R1in(R1in), .R2in(R2in), .R3in(R3in), .MDRin(MDRin), .Read(Read),
    .IncPC(IncPC), .op_code(op_code), .Mdatain(Mdatain), .zlo_contents(zlo_contents)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] dut_reg(int i);
    case (i)
      PC:      return dut.pc_q;
      MAR:     return dut.mar_q;
      MDR:     return dut.mdr_q;
      IR:      return dut.ir_q;
      Y:       return dut.y_q;
      Z:       return zlo_contents;
      R1:      return dut.r1_q;
      R2:      return dut.r2_q;
      default: return dut.r3_q;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    {Clear, PCout, Zlowout, MDRout, R2out, R3out} = '0;
    {MARin, PCin, IRin, Yin, ZLowIn, R1in, R2in, R3in, MDRin, Read, IncPC} = '0;
    op_code = 5'b0;
    Mdatain = 32'h0;
  endtask

  function automatic logic [31:0] model_bus();
    if (PCout)   return m[PC];
    if (Zlowout) return m[Z];
    if (MDRout)  return m[MDR];
    if (R2out)   return m[R2];
    if (R3out)   return m[R3];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_alu(input logic [31:0] b);
    if (IncPC) return b + 32'd1;
    if (op_code == 5'b00010) return m[Y] & b;
    if (op_code == 5'b00001) return m[Y] | b;
`ifdef DATAPATH_ADD_SUB_EN
    if (op_code == 5'b00011) return m[Y] + b;
    if (op_code == 5'b00100) return m[Y] - b;
`endif
    return 32'h0;
  endfunction

  // One control step: predict next state from current inputs, clock, then clear controls.
  task automatic step();
    logic [31:0] b, nxt [9];
    b = model_bus();
    nxt = m;
    if (Clear) begin
      foreach (nxt[i]) nxt[i] = 32'h0;
    end else begin
      if (PCin)   nxt[PC]  = b;
      if (MARin)  nxt[MAR] = b;
      if (MDRin)  nxt[MDR] = Read ? Mdatain : b;
      if (IRin)   nxt[IR]  = b;
      if (Yin)    nxt[Y]   = b;
      if (ZLowIn) nxt[Z]   = model_alu(b);
      if (R1in)   nxt[R1]  = b;
      if (R2in)   nxt[R2]  = b;
      if (R3in)   nxt[R3]  = b;
    end
    @(posedge Clock);
    #1;
    m = nxt;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1; step();
  endtask

  typedef struct {
    logic [31:0] y;
    logic [31:0] b;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    idle();
    tbl[0] = '{32'hFFFF_FFFF, 32'h1234_5678, 5'b00010, 1'b0, 32'h1234_5678};
    tbl[1] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'b00001, 1'b0, 32'hFFFF_FFFF};
    tbl[2] = '{32'h0000_FFFF, 32'h00FF_00FF, 5'b00010, 1'b0, 32'h0000_00FF};
    tbl[3] = '{32'hA5A5_A5A5, 32'h5A5A_0000, 5'b11111, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'h1234_5678, 32'hFFFF_FFFF, 5'b00010, 1'b1, 32'h0000_0000};
    tbl[5] = '{32'h0000_0000, 32'h0000_0041, 5'b00001, 1'b1, 32'h0000_0042};
`ifdef DATAPATH_ADD_SUB_EN
    tbl[6] = '{32'h0000_0005, 32'h0000_0007, 5'b00011, 1'b0, 32'h0000_000C};
    tbl[7] = '{32'h0000_0005, 32'h0000_0007, 5'b00100, 1'b0, 32'hFFFF_FFFE};
`else
    tbl[6] = '{32'h0000_0005, 32'h0000_0007, 5'b00011, 1'b0, 32'h0000_0000};
    tbl[7] = '{32'h0000_0005, 32'h0000_0007, 5'b00100, 1'b0, 32'h0000_0000};
`endif

    Clear = 1'b1; step();
    chk("reset_zlo", zlo_contents, 32'h0);
    chk("reset_pc", dut_reg(PC), 32'h0);

    // ALU vector table: Y and bus both staged through MDR.
    foreach (tbl[i]) begin
      load_mdr(tbl[i].y);
      MDRout = 1'b1; Yin = 1'b1; step();
      load_mdr(tbl[i].b);
      MDRout = 1'b1; op_code = tbl[i].op; IncPC = tbl[i].inc; ZLowIn = 1'b1; step();
      chk($sformatf("alu_vec%0d", i), zlo_contents, tbl[i].exp);
    end

    // Clear has priority over every load on the same edge.
    Clear = 1'b1; MDRout = 1'b1; Read = 1'b1; Mdatain = 32'hDEAD_BEEF;
    {MARin, PCin, IRin, Yin, ZLowIn, R1in, R2in, R3in, MDRin} = '1;
    step();
    for (int i = 0; i < 9; i++) chk($sformatf("clear_reg%0d", i), dut_reg(i), 32'h0);

    load_mdr(32'h0000_00FF);
    MDRout = 1'b1; R2in = 1'b1; step();
    chk("r2_load", dut_reg(R2), 32'h0000_00FF);
    load_mdr(32'h0000_000F);
    MDRout = 1'b1; R3in = 1'b1; step();
    chk("r3_load", dut_reg(R3), 32'h0000_000F);

    R2out = 1'b1; Yin = 1'b1; step();
    R3out = 1'b1; op_code = 5'b00001; ZLowIn = 1'b1; step();
    chk("or_ff_0f", zlo_contents, 32'h0000_00FF);
    Zlowout = 1'b1; R1in = 1'b1; step();
    chk("r1_from_zlow", dut_reg(R1), 32'h0000_00FF);

    R2out = 1'b1; Yin = 1'b1; step();
    R3out = 1'b1; op_code = 5'b00010; ZLowIn = 1'b1; step();
    chk("and_ff_0f", zlo_contents, 32'h0000_000F);

    Clear = 1'b1; step();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; step();
    chk("pc_inc_zlo", zlo_contents, 32'h0000_0001);
    chk("pc_inc_mar", dut_reg(MAR), 32'h0);
    Zlowout = 1'b1; PCin = 1'b1; step();
    chk("pc_is_1", dut_reg(PC), 32'h0000_0001);

    load_mdr(32'hFFFF_FFFF);
    MDRout = 1'b1; PCin = 1'b1; step();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; step();
    chk("pc_wrap", zlo_contents, 32'h0);

    // Y = all ones so AND passes the bus straight through to ZLow.
    MDRout = 1'b1; Yin = 1'b1; step();
    load_mdr(32'h0000_1234);
    PCout = 1'b1; MDRout = 1'b1; op_code = 5'b00010; ZLowIn = 1'b1; step();
    chk("prio_pc_over_mdr", zlo_contents, 32'hFFFF_FFFF);
    MDRout = 1'b1; R2out = 1'b1; op_code = 5'b00010; ZLowIn = 1'b1; step();
    chk("prio_mdr_over_r2", zlo_contents, 32'h0000_1234);
    Zlowout = 1'b1; MDRout = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; step();
    chk("prio_zlow_old_value", zlo_contents, 32'h0000_1235);
    R2out = 1'b1; op_code = 5'b11111; ZLowIn = 1'b1; step();
    chk("unsupported_op", zlo_contents, 32'h0);
    op_code = 5'b00000; ZLowIn = 1'b1; IncPC = 1'b0; R3out = 1'b1; step();
    chk("idle_op_zero", zlo_contents, 32'h0);

    // Randomized control steps against the model.
    for (int n = 0; n < 400; n++) begin
      int unsigned sel;
      Clear   = ($urandom_range(31) == 0);
      PCout   = ($urandom_range(3) == 0);
      Zlowout = ($urandom_range(3) == 0);
      MDRout  = ($urandom_range(2) == 0);
      R2out   = ($urandom_range(2) == 0);
      R3out   = ($urandom_range(2) == 0);
      {MARin, PCin, IRin, Yin, R1in, R2in, R3in, MDRin} = 8'($urandom);
      ZLowIn  = ($urandom_range(1) == 0);
      Read    = 1'($urandom);
      IncPC   = ($urandom_range(7) == 0);
      Mdatain = $urandom;
      sel     = $urandom_range(5);
      case (sel)
        0:       op_code = 5'b00010;
        1:       op_code = 5'b00001;
        2:       op_code = 5'b00011;
        3:       op_code = 5'b00100;
        default: op_code = 5'($urandom);
      endcase
      step();
      for (int i = 0; i < 9; i++) chk($sformatf("rand%0d_reg%0d", n, i), dut_reg(i), m[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
